pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS pipeline.
- Sequences the IF/ID register (stall/flush), the PC write enable, ID/EX bubble insertion and global freeze on data-memory wait.
- Resolves load-use hazards, taken-branch flushes (multi-cycle via counter) and memory stalls with fixed priority.
- Guarantees the IF/ID register never sees flush and hazard asserted together.

Parameters:
- REG_W, 5, register-specifier width
- FLUSH_CYCLES, 1, IF/ID flush cycles per taken branch (1..7)
- MEM_TIMEOUT, 15, consecutive mem_busy_i cycles before timeout_o sets (1..255)

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  synchronous active-low reset
- id_rs_i  input  REG_W  rs of instruction in ID
- id_rt_i  input  REG_W  rt of instruction in ID
- id_uses_rt_i  input  1  ID instruction reads rt
- ex_memread_i  input  1  EX instruction is a load
- ex_rd_i  input  REG_W  destination of EX instruction
- branch_taken_i  input  1  branch resolved taken in ID
- mem_busy_i  input  1  data memory not ready
- pc_write_o  output  1  PC update enable
- ifid_hazard_o  output  1  IF/ID hold (to IFID hazard_i)
- ifid_flush_o  output  1  IF/ID clear (to IFID flush_i)
- idex_bubble_o  output  1  zero ID/EX control fields
- pipe_hold_o  output  1  hold ID/EX, EX/MEM, MEM/WB
- timeout_o  output  1  sticky memory-timeout flag
- state_o  output  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 FLUSH
- stall_cnt_o  output  32  stall cycles (perf option)
- flush_cnt_o  output  32  flush cycles (perf option)

Behaviour:
- Reset: on a clk_i edge with rst_i=0, the following reset together:
  - state -> RUN, flush_cnt -> 0, wait_cnt -> 0, timeout_o -> 0, perf counters -> 0.
  - While rst_i=0, all control outputs are forced 0, including mid-stall or mid-flush.
- Outputs are combinational from registered state plus current inputs. State and counters update on the rising edge.
- Load-use condition LU: ex_memread_i && ex_rd_i!=0 && (ex_rd_i==id_rs_i || (id_uses_rt_i && ex_rd_i==id_rt_i)).
- Default outputs (no event): pc_write_o=1, all other controls 0.
- Per-cycle priority is mem_busy_i > LU > branch_taken_i:
  - Freeze (mem_busy_i=1, any state): pc_write_o=0, ifid_hazard_o=1, pipe_hold_o=1, ifid_flush_o=0, idex_bubble_o=0.
  - LU (mem_busy_i=0): pc_write_o=0, ifid_hazard_o=1, idex_bubble_o=1, for exactly 1 cycle. branch_taken_i is ignored that cycle because ID operands are not valid.
  - Taken branch (no freeze, no LU): ifid_flush_o=1, pc_write_o=1, ifid_hazard_o=0.
- RUN transitions:
  - mem_busy_i -> MEM_WAIT, with wait_cnt=1.
  - Taken branch with FLUSH_CYCLES>1 -> FLUSH, with flush_cnt=FLUSH_CYCLES-1.
  - Otherwise stay in RUN.
- MEM_WAIT:
  - mem_busy_i=1: freeze outputs; wait_cnt saturating increment. timeout_o sets when wait_cnt reaches MEM_TIMEOUT; it stays set until reset.
  - mem_busy_i=0: outputs and next state evaluated exactly as in RUN; wait_cnt cleared. A branch taken in that same cycle is honoured.
- FLUSH:
  - No freeze: ifid_flush_o=1, pc_write_o=1, flush_cnt decrements; returns to RUN when flush_cnt==1 at the edge.
  - mem_busy_i=1: freeze outputs, flush_cnt holds, state stays FLUSH. The frozen cycle does not count as flush.
  - LU and branch_taken_i are ignored while in FLUSH, since ID holds a squashed slot.
- Invariants (assertable):
  - ifid_flush_o & ifid_hazard_o == 0.
  - pc_write_o == 0 implies ifid_hazard_o == 1 (outside reset).

Optional Feature:
- Macro PIPE_HAZARD_CTRL_PERF_EN.
- Defined:
  - stall_cnt_o increments on every cycle with ifid_hazard_o=1.
  - flush_cnt_o increments on every cycle with ifid_flush_o=1.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: no counters are built; both ports are tied to 32'h0.

Test Plan:
- Load-use: ex_memread_i=1, ex_rd_i=8, id_rs_i=8 -> one cycle of pc_write_o=0, ifid_hazard_o=1, idex_bubble_o=1; next cycle with ex_memread_i=0 -> defaults. Repeat with ex_rd_i=0 -> no stall.
- Branch, FLUSH_CYCLES=3: branch_taken_i pulse in RUN -> ifid_flush_o=1 for 3 consecutive cycles, state_o sequence 2,2,0, ifid_hazard_o=0 throughout.
- Priority: mem_busy_i=1 with LU and branch_taken_i both true -> freeze only (flush=0, bubble=0), state_o=1. On mem_busy_i drop with LU still true -> LU stall cycle.
- Timeout, MEM_TIMEOUT=4: mem_busy_i high 4 cycles -> timeout_o=1 on 4th edge, stays 1 after busy drops, cleared only by rst_i=0.
- Reset mid-flush: rst_i=0 during FLUSH with flush_cnt=2 -> outputs 0 immediately. After one edge: state_o=0, no further flush cycles after rst_i=1.
- Perf (PIPE_HAZARD_CTRL_PERF_EN): 2 LU stalls + 1 branch (FLUSH_CYCLES=1) -> stall_cnt_o=2, flush_cnt_o=1. Macro undefined -> both read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline datapath and pipe_hazard_ctrl.
// The pipeline side uses the master modport and the control unit uses the slave modport.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs_i;
  logic [REG_W-1:0] id_rt_i;
  logic             id_uses_rt_i;
  logic             ex_memread_i;
  logic [REG_W-1:0] ex_rd_i;
  logic             branch_taken_i;
  logic             mem_busy_i;
  logic             pc_write_o;
  logic             ifid_hazard_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             pipe_hold_o;
  logic             timeout_o;
  logic [1:0]       state_o;
  logic [31:0]      stall_cnt_o;
  logic [31:0]      flush_cnt_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i, branch_taken_i, mem_busy_i,
    input  pc_write_o, ifid_hazard_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, timeout_o,
           state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i, branch_taken_i, mem_busy_i,
    output pc_write_o, ifid_hazard_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, timeout_o,
           state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush sequencer for the 5-stage MIPS pipeline (priority: mem wait > load-use > branch).
// Optional macro PIPE_HAZARD_CTRL_PERF_EN builds saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [2:0] flush_cnt_r, flush_cnt_nxt_s;
  logic [7:0] wait_cnt_r, wait_cnt_nxt_s;
  logic       timeout_r, timeout_nxt_s;
  logic       lu_s;
  logic       pc_write_s, ifid_hazard_s, ifid_flush_s, idex_bubble_s, pipe_hold_s;

  assign lu_s = hz.ex_memread_i && (hz.ex_rd_i != {REG_W{1'b0}}) &&
                ((hz.ex_rd_i == hz.id_rs_i) || (hz.id_uses_rt_i && (hz.ex_rd_i == hz.id_rt_i)));

  // State and counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r     <= ST_RUN;
      flush_cnt_r <= 3'd0;
      wait_cnt_r  <= 8'd0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      timeout_r   <= timeout_nxt_s;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    timeout_nxt_s   = timeout_r;
    case (state_r)
      ST_RUN, ST_MEM_WAIT: begin
        if (hz.mem_busy_i) begin
          state_nxt_s = ST_MEM_WAIT;
          if (state_r == ST_RUN) begin
            wait_cnt_nxt_s = 8'd1;
          end else if (wait_cnt_r != 8'hFF) begin
            wait_cnt_nxt_s = wait_cnt_r + 8'd1;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r;
          end
          if (wait_cnt_nxt_s >= 8'(MEM_TIMEOUT)) begin
            timeout_nxt_s = 1'b1;
          end else begin
            timeout_nxt_s = timeout_r;
          end
        end else begin
          // A load-use stall suppresses the branch: ID operands are not yet valid.
          wait_cnt_nxt_s = 8'd0;
          if (!lu_s && hz.branch_taken_i && (FLUSH_CYCLES > 1)) begin
            state_nxt_s     = ST_FLUSH;
            flush_cnt_nxt_s = 3'(FLUSH_CYCLES - 1);
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        if (hz.mem_busy_i) begin
          state_nxt_s = ST_FLUSH;
        end else if (flush_cnt_r == 3'd1) begin
          state_nxt_s     = ST_RUN;
          flush_cnt_nxt_s = 3'd0;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r - 3'd1;
        end
      end
      default: begin
        state_nxt_s     = ST_RUN;
        flush_cnt_nxt_s = 3'd0;
      end
    endcase
  end

  // Control outputs from registered state and current inputs
  always_comb begin
    pc_write_s    = 1'b1;
    ifid_hazard_s = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    pipe_hold_s   = 1'b0;
    if (!rst_i) begin
      pc_write_s = 1'b0;
    end else if (hz.mem_busy_i) begin
      pc_write_s    = 1'b0;
      ifid_hazard_s = 1'b1;
      pipe_hold_s   = 1'b1;
    end else if (state_r == ST_FLUSH) begin
      ifid_flush_s = 1'b1;
    end else if (lu_s) begin
      pc_write_s    = 1'b0;
      ifid_hazard_s = 1'b1;
      idex_bubble_s = 1'b1;
    end else if (hz.branch_taken_i) begin
      ifid_flush_s = 1'b1;
    end else begin
      pc_write_s = 1'b1;
    end
  end

  assign hz.pc_write_o    = pc_write_s;
  assign hz.ifid_hazard_o = ifid_hazard_s;
  assign hz.ifid_flush_o  = ifid_flush_s;
  assign hz.idex_bubble_o = idex_bubble_s;
  assign hz.pipe_hold_o   = pipe_hold_s;
  assign hz.timeout_o     = timeout_r;
  assign hz.state_o       = state_r;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_r, flush_perf_r;

  // Saturating performance counters for stall and flush cycles
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_r  <= 32'h0;
      flush_perf_r <= 32'h0;
    end else begin
      if (ifid_hazard_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'h1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (ifid_flush_s && (flush_perf_r != 32'hFFFF_FFFF)) begin
        flush_perf_r <= flush_perf_r + 32'h1;
      end else begin
        flush_perf_r <= flush_perf_r;
      end
    end
  end

  assign hz.stall_cnt_o = stall_cnt_r;
  assign hz.flush_cnt_o = flush_perf_r;
`else
  assign hz.stall_cnt_o = 32'h0;
  assign hz.flush_cnt_o = 32'h0;
`endif

endmodule
